// File: rtl/cbm2_mem_arbiter.sv
// CBM-II shared memory arbiter: grants one of NUM_M bus masters access to the
// system memory port with a request/acknowledge handshake. Master 0 (video)
// may optionally hold fixed top priority; the remaining masters share the
// port round-robin. Each master keeps its own last-read byte.
module cbm2_mem_arbiter #(
  parameter int NUM_M    = 3,
  parameter int ADDR_W   = 25,
  parameter int DATA_W   = 8,
  parameter int VID_PRIO = 1,
  parameter int TIMEOUT  = 15,
  parameter logic [DATA_W-1:0] IDLE_DATA = 8'hFF
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic [NUM_M-1:0]           m_req,
  input  logic [NUM_M-1:0]           m_we,
  input  logic [NUM_M*ADDR_W-1:0]    m_addr,
  input  logic [NUM_M*DATA_W-1:0]    m_wdata,
  output logic [NUM_M-1:0]           m_ack,
  output logic [NUM_M*DATA_W-1:0]    m_rdata,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_ack,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic [2:0]                 grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  // Last WAIT cycle index: the counter starts at 0 in the first WAIT cycle.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]  gid;
  logic [IDX_W-1:0]  rr;
  logic [7:0]        cnt;
  logic              tmo_hit;

  logic              win_vld;
  logic [IDX_W-1:0]  win_sel;
  logic [IDX_W-1:0]  cand;

  logic [ADDR_W-1:0] addr_a  [NUM_M];
  logic [DATA_W-1:0] wdata_a [NUM_M];
  logic [DATA_W-1:0] rdata_q [NUM_M];

  genvar g;
  generate
    for (g = 0; g < NUM_M; g++) begin : g_unpack
      assign addr_a[g]  = m_addr[g*ADDR_W +: ADDR_W];
      assign wdata_a[g] = m_wdata[g*DATA_W +: DATA_W];
      assign m_rdata[g*DATA_W +: DATA_W] = rdata_q[g];
    end
  endgenerate

  assign tmo_hit  = (cnt == TMO_LAST);
  assign grant_id = 3'(gid);

  // Winner selection: optional video override, otherwise search from rr+1.
  // With video priority, master 0 is skipped by the rotating search so the
  // pointer only ever tracks the non-video masters.
  always_comb begin
    win_vld = 1'b0;
    win_sel = '0;
    cand    = '0;
    if (VID_PRIO != 0 && m_req[0]) begin
      win_vld = 1'b1;
    end else begin
      for (int i = 1; i <= NUM_M; i++) begin
        cand = IDX_W'((int'(rr) + i) % NUM_M);
        if (!win_vld && m_req[cand] && !(VID_PRIO != 0 && cand == '0)) begin
          win_vld = 1'b1;
          win_sel = cand;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and strobe outputs (memory strobe, completion pulse, busy).
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    m_ack     = '0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE:  if (win_vld) state_nxt = S_ISSUE;
      S_ISSUE: begin
        mem_req   = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT:  if (mem_ack || tmo_hit) state_nxt = S_DONE;
      S_DONE: begin
        m_ack[gid] = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grant capture, timeout counting and per-master read-data update.
  // An ack in the final WAIT cycle takes precedence over the timeout.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      gid         <= '0;
      rr          <= '0;
      cnt         <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      timeout_err <= 1'b0;
      for (int i = 0; i < NUM_M; i++) rdata_q[i] <= IDLE_DATA;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            gid       <= win_sel;
            mem_addr  <= addr_a[win_sel];
            mem_we    <= m_we[win_sel];
            mem_wdata <= wdata_a[win_sel];
            if (VID_PRIO == 0 || win_sel != '0) rr <= win_sel;
          end
        end
        S_ISSUE: cnt <= '0;
        S_WAIT: begin
          cnt <= cnt + 8'd1;
          if (mem_ack) begin
            if (!mem_we) rdata_q[gid] <= mem_rdata;
          end else if (tmo_hit) begin
            if (!mem_we) rdata_q[gid] <= IDLE_DATA;
            timeout_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cbm2_mem_arbiter.sv
// Directed bench for cbm2_mem_arbiter: one instance with video priority and a
// scripted memory responder, one round-robin instance with an always-ready
// memory. Expected completions are queued when a request is driven and
// compared when the matching m_ack pulse appears.
module tb_cbm2_mem_arbiter;

  localparam int NM = 3;
  localparam int AW = 25;
  localparam int DW = 8;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [NM-1:0]    m_req, m_we;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [NM-1:0]    m_ack;
  logic [NM*DW-1:0] m_rdata;
  logic             mem_req, mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic             mem_ack = 1'b0;
  logic [DW-1:0]    mem_rdata = '0;
  logic [2:0]       grant_id;
  logic             busy, timeout_err;

  logic [NM-1:0]    r_req;
  logic [NM-1:0]    r_ack;
  logic [NM*DW-1:0] r_rdata;
  logic             r_mem_req, r_mem_we;
  logic [AW-1:0]    r_mem_addr;
  logic [DW-1:0]    r_mem_wdata;
  logic [2:0]       r_grant_id;
  logic             r_busy, r_timeout_err;

  cbm2_mem_arbiter #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW), .VID_PRIO(1),
                     .TIMEOUT(15), .IDLE_DATA(8'hFF)) u_dut (
    .clk_sys(clk), .reset(reset),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  cbm2_mem_arbiter #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW), .VID_PRIO(0),
                     .TIMEOUT(15), .IDLE_DATA(8'hFF)) u_rr (
    .clk_sys(clk), .reset(reset),
    .m_req(r_req), .m_we('0), .m_addr('0), .m_wdata('0),
    .m_ack(r_ack), .m_rdata(r_rdata),
    .mem_req(r_mem_req), .mem_we(r_mem_we), .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
    .mem_ack(1'b1), .mem_rdata(8'h77),
    .grant_id(r_grant_id), .busy(r_busy), .timeout_err(r_timeout_err)
  );

  typedef struct {
    int         idx;
    logic [7:0] rd;
  } exp_t;

  exp_t q[$];
  exp_t e;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Memory responder: resp_delay WAIT cycles without ack, then one ack cycle.
  // A negative delay never acknowledges.
  int         resp_delay = -1;
  logic [7:0] resp_data  = 8'h00;
  int         wcnt       = -1;
  int         iss_cnt    = 0;
  int         ack_cnt    = 0;
  logic       iss_we     = 1'b0;
  logic [7:0] iss_wdata  = '0;
  logic [AW-1:0] iss_addr = '0;

  always @(negedge clk) begin
    ack_cnt = ack_cnt + $countones(m_ack);
    mem_ack = 1'b0;
    if (mem_req) begin
      iss_cnt   = iss_cnt + 1;
      iss_we    = mem_we;
      iss_wdata = mem_wdata;
      iss_addr  = mem_addr;
      wcnt      = resp_delay;
    end else if (wcnt == 0) begin
      mem_ack   = 1'b1;
      mem_rdata = resp_data;
      wcnt      = -1;
    end else if (wcnt > 0) begin
      wcnt = wcnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int idx, input logic [7:0] rd);
    exp_t t;
    t.idx = idx;
    t.rd  = rd;
    q.push_back(t);
  endtask

  // Waits (bounded) for an ack pulse; cyc counts negedges after the call.
  task automatic wait_ack(input bit sel, input int limit, output int idx, output int cyc);
    logic [NM-1:0] a;
    idx = -1;
    cyc = 0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      cyc++;
      a = sel ? r_ack : m_ack;
      if (a != '0) begin
        for (int b = 0; b < NM; b++) if (a[b] && idx < 0) idx = b;
        break;
      end
    end
  endtask

  function automatic logic [7:0] rd(input int i);
    return m_rdata[i*DW +: DW];
  endfunction

  function automatic logic [7:0] rrd(input int i);
    return r_rdata[i*DW +: DW];
  endfunction

  initial begin
    int idx, cyc, i0, a0;
    int ord3[7] = '{0, 1, 0, 2, 0, 1, 0};
    int ord4[6] = '{1, 2, 0, 1, 2, 0};

    reset = 1'b1;
    m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; r_req = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_m_ack", m_ack, 0);
    check("rst_m_rdata", m_rdata, 24'hFFFFFF);
    check("rst_grant_id", grant_id, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_we", mem_we, 0);
    reset = 1'b0;
    @(negedge clk);

    // CPU read, ack after two idle WAIT cycles
    m_addr[1*AW +: AW] = 25'h0FE000;
    resp_delay = 2; resp_data = 8'h4C;
    i0 = iss_cnt;
    push(1, 8'h4C);
    m_req = 3'b010;
    wait_ack(0, 40, idx, cyc);
    m_req = '0;
    e = q.pop_front();
    check("t1_idx", idx, e.idx);
    check("t1_latency", cyc + 1, 6);
    check("t1_rdata1", rd(1), e.rd);
    check("t1_rdata0", rd(0), 8'hFF);
    check("t1_rdata2", rd(2), 8'hFF);
    check("t1_issue_count", iss_cnt - i0, 1);
    check("t1_addr", iss_addr, 25'h0FE000);
    check("t1_we", iss_we, 0);
    check("t1_grant_id", grant_id, 1);
    @(negedge clk);
    check("t1_idle_busy", busy, 0);

    // Master 2 write
    m_addr[2*AW +: AW] = 25'h010000;
    m_wdata[2*DW +: DW] = 8'h5A;
    m_we = 3'b100;
    resp_delay = 0; resp_data = 8'h33;
    push(2, 8'hFF);
    m_req = 3'b100;
    wait_ack(0, 40, idx, cyc);
    m_req = '0; m_we = '0;
    e = q.pop_front();
    check("t2_idx", idx, e.idx);
    check("t2_latency", cyc + 1, 4);
    check("t2_we", iss_we, 1);
    check("t2_wdata", iss_wdata, 8'h5A);
    check("t2_addr", iss_addr, 25'h010000);
    check("t2_rdata2", rd(2), e.rd);
    check("t2_rdata1", rd(1), 8'h4C);
    @(negedge clk);

    // Contention with video priority; acked master drops request briefly
    resp_delay = 1; resp_data = 8'hA5;
    for (int k = 0; k < 7; k++) push(ord3[k], 8'hA5);
    i0 = iss_cnt; a0 = ack_cnt;
    m_req = 3'b111;
    for (int k = 0; k < 7; k++) begin
      wait_ack(0, 60, idx, cyc);
      e = q.pop_front();
      check("t3_order", idx, e.idx);
      check("t3_onehot", $onehot(m_ack), 1);
      check("t3_rdata", rd(e.idx), e.rd);
      if (idx >= 0) m_req[idx] = 1'b0;
      if (k == 6) m_req = '0;
      else begin
        repeat (2) @(negedge clk);
        if (idx >= 0) m_req[idx] = 1'b1;
      end
    end
    repeat (3) @(negedge clk);
    check("t3_busy_end", busy, 0);
    check("t3_issue_count", iss_cnt - i0, 7);
    check("t3_ack_count", ack_cnt - a0, 7);

    // Round-robin instance
    for (int k = 0; k < 6; k++) push(ord4[k], 8'h77);
    r_req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      wait_ack(1, 60, idx, cyc);
      e = q.pop_front();
      check("t4_order", idx, e.idx);
      check("t4_onehot", $onehot(r_ack), 1);
      check("t4_rdata", rrd(e.idx), e.rd);
      if (idx >= 0) r_req[idx] = 1'b0;
      if (k == 5) r_req = '0;
      else begin
        repeat (2) @(negedge clk);
        if (idx >= 0) r_req[idx] = 1'b1;
      end
    end
    repeat (3) @(negedge clk);

    // Timeout with no ack
    m_addr[1*AW +: AW] = 25'h0FE001;
    resp_delay = -1;
    push(1, 8'hFF);
    m_req = 3'b010;
    wait_ack(0, 60, idx, cyc);
    m_req = '0;
    e = q.pop_front();
    check("t5_idx", idx, e.idx);
    check("t5_latency", cyc + 1, 18);
    check("t5_rdata1", rd(1), e.rd);
    check("t5_timeout_err", timeout_err, 1);
    repeat (4) @(negedge clk);
    check("t5_timeout_sticky", timeout_err, 1);
    reset = 1'b1;
    @(negedge clk);
    check("t5_timeout_cleared", timeout_err, 0);
    reset = 1'b0;
    @(negedge clk);

    // Ack in the same cycle as the timeout
    resp_delay = 14; resp_data = 8'h3C;
    push(2, 8'h3C);
    m_req = 3'b100;
    wait_ack(0, 60, idx, cyc);
    m_req = '0;
    e = q.pop_front();
    check("t5b_idx", idx, e.idx);
    check("t5b_latency", cyc + 1, 18);
    check("t5b_rdata2", rd(2), e.rd);
    check("t5b_timeout_err", timeout_err, 0);
    @(negedge clk);

    // Asynchronous reset while waiting on memory
    m_addr[2*AW +: AW] = 25'h01ABCD;
    resp_delay = -1;
    m_req = 3'b100;
    repeat (5) @(negedge clk);
    check("t6_busy_wait", busy, 1);
    check("t6_addr_wait", mem_addr, 25'h01ABCD);
    a0 = ack_cnt;
    #2 reset = 1'b1;
    #1;
    check("t6_busy", busy, 0);
    check("t6_mem_req", mem_req, 0);
    check("t6_mem_addr", mem_addr, 0);
    check("t6_grant_id", grant_id, 0);
    check("t6_m_rdata", m_rdata, 24'hFFFFFF);
    check("t6_m_ack", m_ack, 0);
    repeat (2) @(negedge clk);
    check("t6_no_ack", ack_cnt - a0, 0);
    resp_delay = 0; resp_data = 8'h99;
    push(2, 8'h99);
    reset = 1'b0;
    wait_ack(0, 40, idx, cyc);
    m_req = '0;
    e = q.pop_front();
    check("t6_idx", idx, e.idx);
    check("t6_latency", cyc + 1, 4);
    check("t6_rdata2", rd(2), e.rd);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cbm2_mem_arbiter.md
Name: cbm2_mem_arbiter

Overview:
Parametrised multi-master memory arbiter for the CBM-II core. It replaces the fixed CPU/video slot split with request/acknowledge access for N bus masters (6509 CPU, IPC co-processor, VIC/CRTC fetch, DMA/loader) to the shared system memory port. Each master gets a held read-data register, so every master keeps its own last-read byte. Sits between the masters and the SDRAM/BRAM address mux that feeds systemAddr/systemWe.

Parameters:
NUM_M, 3, number of masters (2..8); index 0 is the video master.
ADDR_W, 25, system address width.
DATA_W, 8, data width.
VID_PRIO, 1, 1 = master 0 has fixed top priority; 0 = all masters round-robin.
TIMEOUT, 15, max cycles waiting for mem_ack before forced completion (1..255).
IDLE_DATA, 8'hFF, read data returned on timeout.

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous, active-high reset
m_req  in  NUM_M  per-master request level; held until m_ack
m_we  in  NUM_M  per-master write enable, sampled at grant
m_addr  in  NUM_M*ADDR_W  packed per-master address
m_wdata  in  NUM_M*DATA_W  packed per-master write data
m_ack  out  NUM_M  one-cycle completion pulse per master
m_rdata  out  NUM_M*DATA_W  per-master held read data
mem_req  out  1  memory request strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  memory completion; read data valid in the same cycle
mem_rdata  in  DATA_W  memory read data
grant_id  out  3  index of the current/last granted master
busy  out  1  high in any state except IDLE
timeout_err  out  1  sticky flag for a forced completion; cleared only by reset

Behaviour:
- Reset (async assert, sync release): state IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, m_ack=0, all m_rdata=IDLE_DATA, grant_id=0, busy=0, timeout_err=0, rr pointer=0.
- FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE: when any m_req is high, choose the winner and register grant_id, mem_addr, mem_we, mem_wdata from the winner's inputs. Go to ISSUE.
- Selection when VID_PRIO=1: if m_req[0] is set, master 0 wins. Otherwise round-robin applies over masters 1..NUM_M-1.
- Selection when VID_PRIO=0: round-robin over all masters. The search starts at rr+1 mod NUM_M; rr is updated to the winner.
- ISSUE: mem_req=1 for exactly one cycle; timeout counter cleared. Go to WAIT.
- WAIT: mem_req=0; counter increments each cycle.
  - mem_ack=1 on a read: m_rdata[grant_id] <= mem_rdata. Go to DONE.
  - mem_ack=1 on a write: m_rdata is unchanged. Go to DONE.
  - Counter reaches TIMEOUT with no ack: read sets m_rdata[grant_id] <= IDLE_DATA; timeout_err <= 1; go to DONE.
  - mem_ack and the timeout in the same cycle: the ack wins and timeout_err is not set.
- DONE: m_ack[grant_id]=1 for one cycle. Go to IDLE; no new grant is made in this cycle.
- Latency: minimum request-to-ack is 4 cycles (IDLE sample, ISSUE, WAIT with immediate ack, DONE), plus the memory wait cycles.
- mem_ack arriving outside WAIT is ignored.
- A master dropping m_req after grant does not abort the transaction; its m_ack still pulses.
- m_rdata of non-granted masters never change.
- mem_addr/mem_we/mem_wdata hold their values from grant until the next grant.
- reset asserted mid-transaction: immediate return to reset values; no m_ack pulses.
- grant_id is zero-extended when fewer than 8 masters are present.

Test Plan:
1. CPU read: m_req[1]=1, addr 0x0F_E000; mem_ack after 2 WAIT cycles with rdata 0x4C -> mem_req pulses once; m_ack[1] pulses 6 cycles after the request; m_rdata[1]=0x4C; m_rdata[0]/[2] remain 0xFF.
2. Write: master 2 writes 0x5A to 0x01_0000 -> mem_we=1, mem_wdata=0x5A during ISSUE; m_rdata[2] unchanged; m_ack[2] pulses.
3. Contention with VID_PRIO=1: m_req=3'b111 held -> grant order is 0,1,0,2,0,1; every access gets exactly one m_ack.
4. Round-robin with VID_PRIO=0: m_req=3'b111 held -> grant order is 1,2,0,1,2,0.
5. Timeout: no mem_ack, TIMEOUT=15 -> forced DONE after 15 WAIT cycles; m_rdata=0xFF; timeout_err=1 until reset. Second case: ack and timeout in the same cycle -> data taken from mem_rdata, timeout_err stays 0.
6. Reset in WAIT: assert reset asynchronously -> outputs return to reset values with no clock edge; no m_ack. After release, a pending m_req is granted normally.
